uart_tx_queue: RTL and testbench

//   Byte queue and sender placed directly upstream of the UART transmitter.

---
 rtl/uart_pkg.sv | 14 +
 rtl/sync_fifo.sv | 54 +++++
 rtl/uart_tx_queue.sv | 79 +++++++
 tb/tb_uart_tx_queue.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit queue.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    SEND      = 2'd1,
    WAIT_LOW  = 2'd2,
    WAIT_HIGH = 2'd3
  } tx_state_t;

  localparam int UART_DATA_W      = 8;
  localparam int WAIT_LOW_TIMEOUT = 4;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock circular FIFO with registered full/empty/count and an overflow pulse.
module sync_fifo #(
  parameter int  DEPTH = 16,
  parameter int  W     = 8,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         wr_en,
  input  logic [W-1:0] wr_data,
  input  logic         rd_en,
  output logic [W-1:0] rd_data,
  output logic         full,
  output logic         empty,
  output logic [AW:0]  count,
  output logic         overflow
);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          wr_ok;
  logic          rd_ok;
  logic [AW:0]   count_nxt;

  // A pop while full never frees room for the same cycle's write.
  assign wr_ok     = wr_en & ~full;
  assign rd_ok     = rd_en & ~empty;
  assign count_nxt = count + (AW+1)'(wr_ok) - (AW+1)'(rd_ok);
  assign rd_data   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      full     <= 1'b0;
      empty    <= 1'b1;
      overflow <= 1'b0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + AW'(1);
      if (rd_ok) rd_ptr <= rd_ptr + AW'(1);
      count    <= count_nxt;
      full     <= (count_nxt == (AW+1)'(DEPTH));
      empty    <= (count_nxt == '0);
      overflow <= wr_en & full;
    end
  end

  always_ff @(posedge clk) begin
    if (rst && wr_ok) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/uart_tx_queue.sv
// Byte queue feeding a UART transmitter: buffers producer writes and paces them
// into the UART ready/send/data handshake, one byte per frame.
module uart_tx_queue
  import uart_pkg::*;
#(
  parameter int  DEPTH = 16,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr_en,
  input  logic [UART_DATA_W-1:0] wr_data,
  output logic                   full,
  output logic                   empty,
  output logic [AW:0]            count,
  output logic                   overflow,
  input  logic                   uart_ready,
  output logic                   uart_send,
  output logic [UART_DATA_W-1:0] uart_data
);

  localparam int TW = (WAIT_LOW_TIMEOUT > 1) ? $clog2(WAIT_LOW_TIMEOUT) : 1;

  tx_state_t              state;
  logic [TW-1:0]          to_cnt;
  logic                   pop;
  logic [UART_DATA_W-1:0] head;

  sync_fifo #(
    .DEPTH (DEPTH),
    .W     (UART_DATA_W)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (wr_en),
    .wr_data  (wr_data),
    .rd_en    (pop),
    .rd_data  (head),
    .full     (full),
    .empty    (empty),
    .count    (count),
    .overflow (overflow)
  );

  assign pop       = (state == IDLE) & ~empty & uart_ready;
  assign uart_send = (state == SEND);

  // uart_data is only loaded on a pop, so it stays put for the whole frame.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      to_cnt    <= '0;
      uart_data <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pop) begin
            uart_data <= head;
            state     <= SEND;
          end
        end
        SEND: begin
          to_cnt <= '0;
          state  <= WAIT_LOW;
        end
        WAIT_LOW: begin
          // Timeout covers a UART whose ready never visibly drops.
          if (!uart_ready || to_cnt == TW'(WAIT_LOW_TIMEOUT - 1)) state <= WAIT_HIGH;
          else to_cnt <= to_cnt + TW'(1);
        end
        WAIT_HIGH: begin
          if (uart_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_queue.sv
// Directed bench for uart_tx_queue with a behavioural UART (ready low 20 cycles per frame).
module tb_uart_tx_queue;

  localparam int DEPTH = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       full;
  logic       empty;
  logic [4:0] count;
  logic       overflow;
  logic       uart_ready;
  logic       uart_send;
  logic [7:0] uart_data;

  logic       m_ready = 1'b1;
  logic       hold    = 1'b0;
  int         busy    = 0;
  int         n_send  = 0;
  int         ovf_cnt = 0;
  logic [7:0] rx_q [$];

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  assign uart_ready = m_ready & ~hold;

  uart_tx_queue #(.DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .wr_en      (wr_en),
    .wr_data    (wr_data),
    .full       (full),
    .empty      (empty),
    .count      (count),
    .overflow   (overflow),
    .uart_ready (uart_ready),
    .uart_send  (uart_send),
    .uart_data  (uart_data)
  );

  // UART model: ignores the queue's reset and always finishes its frame.
  always @(posedge clk) begin
    if (uart_send === 1'b1) begin
      rx_q.push_back(uart_data);
      n_send  <= n_send + 1;
      m_ready <= 1'b0;
      busy    <= 20;
    end else if (busy > 0) begin
      busy <= busy - 1;
      if (busy == 1) m_ready <= 1'b1;
    end
  end

  always @(negedge clk) begin
    if (overflow === 1'b1) ovf_cnt++;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_rx(input int n, input string name);
    int i;
    i = 0;
    while (rx_q.size() < n && i < 1000) begin
      tick();
      i++;
    end
    n_checks++;
    if (rx_q.size() != n) begin
      n_errors++;
      $display("FAIL %s_rx_count: got %0d bytes, want %0d", name, rx_q.size(), n);
    end
    repeat (30) tick();
  endtask

  task automatic test_reset();
    rst = 1'b0; wr_en = 1'b1; wr_data = 8'h77;
    repeat (3) tick();
    n_checks++; if (count !== 5'd0) begin n_errors++; $display("FAIL reset_count: got %0d want 0", count); end
    n_checks++; if (empty !== 1'b1) begin n_errors++; $display("FAIL reset_empty: got %b want 1", empty); end
    n_checks++; if (full !== 1'b0) begin n_errors++; $display("FAIL reset_full: got %b want 0", full); end
    n_checks++; if (uart_send !== 1'b0) begin n_errors++; $display("FAIL reset_send: got %b want 0", uart_send); end
    n_checks++; if (uart_data !== 8'h00) begin n_errors++; $display("FAIL reset_data: got %h want 00", uart_data); end
    n_checks++; if (overflow !== 1'b0) begin n_errors++; $display("FAIL reset_overflow: got %b want 0", overflow); end
    wr_en = 1'b0; rst = 1'b1;
    repeat (5) tick();
    n_checks++; if (n_send != 0) begin n_errors++; $display("FAIL reset_nosend: got %0d sends want 0", n_send); end
    n_checks++; if (empty !== 1'b1) begin n_errors++; $display("FAIL reset_after_empty: got %b want 1", empty); end
  endtask

  task automatic test_single();
    int  base;
    logic held;
    base = n_send; rx_q.delete();
    wr_data = 8'hA5; wr_en = 1'b1;
    tick();
    wr_en = 1'b0;
    n_checks++; if (count !== 5'd1) begin n_errors++; $display("FAIL single_count_k: got %0d want 1", count); end
    n_checks++; if (uart_send !== 1'b0) begin n_errors++; $display("FAIL single_send_early: got %b want 0", uart_send); end
    tick();
    n_checks++; if (uart_send !== 1'b1) begin n_errors++; $display("FAIL single_send: got %b want 1", uart_send); end
    n_checks++; if (uart_data !== 8'hA5) begin n_errors++; $display("FAIL single_data: got %h want a5", uart_data); end
    n_checks++; if (count !== 5'd0) begin n_errors++; $display("FAIL single_count_pop: got %0d want 0", count); end
    tick();
    n_checks++; if (uart_send !== 1'b0) begin n_errors++; $display("FAIL single_send_pulse: got %b want 0", uart_send); end
    held = 1'b1;
    repeat (22) begin
      if (uart_data !== 8'hA5) held = 1'b0;
      tick();
    end
    n_checks++; if (held !== 1'b1) begin n_errors++; $display("FAIL single_data_hold: got %h want a5 throughout", uart_data); end
    repeat (10) tick();
    n_checks++; if (n_send - base != 1) begin n_errors++; $display("FAIL single_pulses: got %0d want 1", n_send - base); end
  endtask

  task automatic test_burst();
    int base;
    base = n_send; rx_q.delete();
    for (int i = 1; i <= 5; i++) begin
      wr_data = 8'(i); wr_en = 1'b1;
      tick();
    end
    wr_en = 1'b0;
    wait_rx(5, "burst");
    for (int i = 0; i < 5 && i < rx_q.size(); i++) begin
      n_checks++;
      if (rx_q[i] !== 8'(i + 1)) begin n_errors++; $display("FAIL burst_order[%0d]: got %h want %h", i, rx_q[i], 8'(i + 1)); end
    end
    n_checks++; if (n_send - base != 5) begin n_errors++; $display("FAIL burst_pulses: got %0d want 5", n_send - base); end
    n_checks++; if (empty !== 1'b1) begin n_errors++; $display("FAIL burst_empty: got %b want 1", empty); end
  endtask

  task automatic test_overflow();
    int base_ovf;
    hold = 1'b1; rx_q.delete(); base_ovf = ovf_cnt;
    for (int i = 0; i < DEPTH; i++) begin
      wr_data = 8'h10 + 8'(i); wr_en = 1'b1;
      tick();
    end
    n_checks++; if (full !== 1'b1) begin n_errors++; $display("FAIL ovf_full: got %b want 1", full); end
    n_checks++; if (count !== 5'd16) begin n_errors++; $display("FAIL ovf_count: got %0d want 16", count); end
    n_checks++; if (overflow !== 1'b0) begin n_errors++; $display("FAIL ovf_early: got %b want 0", overflow); end
    wr_data = 8'hEE;
    tick();
    wr_en = 1'b0;
    n_checks++; if (overflow !== 1'b1) begin n_errors++; $display("FAIL ovf_pulse: got %b want 1", overflow); end
    n_checks++; if (count !== 5'd16) begin n_errors++; $display("FAIL ovf_count_kept: got %0d want 16", count); end
    tick();
    n_checks++; if (overflow !== 1'b0) begin n_errors++; $display("FAIL ovf_pulse_len: got %b want 0", overflow); end
    n_checks++; if (ovf_cnt - base_ovf != 1) begin n_errors++; $display("FAIL ovf_pulses: got %0d want 1", ovf_cnt - base_ovf); end
    hold = 1'b0;
    wait_rx(16, "ovf");
    for (int i = 0; i < 16 && i < rx_q.size(); i++) begin
      n_checks++;
      if (rx_q[i] !== 8'h10 + 8'(i)) begin n_errors++; $display("FAIL ovf_order[%0d]: got %h want %h", i, rx_q[i], 8'h10 + 8'(i)); end
    end
    repeat (60) tick();
    n_checks++; if (rx_q.size() != 16) begin n_errors++; $display("FAIL ovf_dropped: got %0d bytes want 16", rx_q.size()); end
    n_checks++; if (empty !== 1'b1) begin n_errors++; $display("FAIL ovf_empty: got %b want 1", empty); end
  endtask

  task automatic test_simultaneous();
    hold = 1'b1; rx_q.delete();
    for (int i = 0; i < 3; i++) begin
      wr_data = 8'h31 + 8'(i); wr_en = 1'b1;
      tick();
    end
    wr_en = 1'b0;
    tick();
    n_checks++; if (count !== 5'd3) begin n_errors++; $display("FAIL simul_pre_count: got %0d want 3", count); end
    hold = 1'b0; wr_data = 8'h34; wr_en = 1'b1;
    tick();
    wr_en = 1'b0;
    n_checks++; if (count !== 5'd3) begin n_errors++; $display("FAIL simul_count: got %0d want 3", count); end
    n_checks++; if (uart_send !== 1'b1) begin n_errors++; $display("FAIL simul_pop: got %b want 1", uart_send); end
    wait_rx(4, "simul");
    for (int i = 0; i < 4 && i < rx_q.size(); i++) begin
      n_checks++;
      if (rx_q[i] !== 8'h31 + 8'(i)) begin n_errors++; $display("FAIL simul_order[%0d]: got %h want %h", i, rx_q[i], 8'h31 + 8'(i)); end
    end
  endtask

  task automatic test_reset_midframe();
    int base;
    hold = 1'b1; rx_q.delete();
    for (int i = 0; i < 5; i++) begin
      wr_data = 8'h61 + 8'(i); wr_en = 1'b1;
      tick();
    end
    wr_en = 1'b0;
    base = n_send; hold = 1'b0;
    repeat (6) tick();
    n_checks++; if (count !== 5'd4) begin n_errors++; $display("FAIL mid_count: got %0d want 4", count); end
    n_checks++; if (uart_ready !== 1'b0) begin n_errors++; $display("FAIL mid_inframe: got ready %b want 0", uart_ready); end
    rst = 1'b0;
    tick();
    rst = 1'b1;
    n_checks++; if (count !== 5'd0) begin n_errors++; $display("FAIL mid_rst_count: got %0d want 0", count); end
    n_checks++; if (empty !== 1'b1) begin n_errors++; $display("FAIL mid_rst_empty: got %b want 1", empty); end
    n_checks++; if (uart_data !== 8'h00) begin n_errors++; $display("FAIL mid_rst_data: got %h want 00", uart_data); end
    repeat (60) tick();
    n_checks++; if (n_send - base != 1) begin n_errors++; $display("FAIL mid_nosend: got %0d sends want 1", n_send - base); end
    wr_data = 8'h7A; wr_en = 1'b1;
    tick();
    wr_en = 1'b0;
    wait_rx(2, "mid");
    n_checks++; if (n_send - base != 2) begin n_errors++; $display("FAIL mid_newsend: got %0d sends want 2", n_send - base); end
    n_checks++;
    if (rx_q.size() < 2 || rx_q[rx_q.size() - 1] !== 8'h7A) begin
      n_errors++;
      $display("FAIL mid_newdata: got %h want 7a", (rx_q.size() > 0) ? rx_q[rx_q.size() - 1] : 8'hxx);
    end
  endtask

  initial begin
    rst = 1'b0; wr_en = 1'b0; wr_data = 8'h00;
    test_reset();
    test_single();
    test_burst();
    test_overflow();
    test_simultaneous();
    test_reset_midframe();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
